// File: rtl/button_debounce_pkg.sv
// Shared definitions for the push-button front end.
//   BTN_LEFT/RIGHT/UP/DOWN : bit positions of each button in the 4-bit vectors
//   BTN_W                  : number of buttons
// direction_ctrl wiring indexes btn_level with these positions as well.
package button_debounce_pkg;

    localparam int unsigned BTN_LEFT  = 0;
    localparam int unsigned BTN_RIGHT = 1;
    localparam int unsigned BTN_UP    = 2;
    localparam int unsigned BTN_DOWN  = 3;
    localparam int unsigned BTN_W     = 4;

endpackage

// File: rtl/debounce_ch.sv
// Single-button debouncer channel.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   tick   : shared sample strobe; channel state moves only on tick cycles
//   raw    : polarity-corrected asynchronous button pin (1 = pressed)
//   level  : debounced pressed level
//   press  : one-cycle pulse on debounced 0->1
//   rls    : one-cycle pulse on debounced 1->0
// The release pulse is named rls because "release" is a reserved word.
module debounce_ch #(
    parameter int unsigned STABLE_CNT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rls
);

    localparam int unsigned CW = $clog2(STABLE_CNT) + 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
            rls   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            rls   <= 1'b0;
            if (tick) begin
                // Any sample agreeing with the current level restarts the
                // count, so only an uninterrupted run of STABLE_CNT
                // disagreeing ticks flips the level.
                if (sync2 == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(STABLE_CNT - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                    rls   <= ~sync2;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Front-end conditioning for the four raw board push-buttons.
//   clk         : system clock, single domain
//   rst_n       : asynchronous active-low reset
//   btn_raw     : raw pins [0]=left [1]=right [2]=up [3]=down
//   btn_level   : debounced pressed level, 1 = pressed
//   btn_press   : one-cycle pulse on debounced 0->1
//   btn_release : one-cycle pulse on debounced 1->0
//   tick        : sample-tick strobe shared by all channels
// Parameters: TICK_DIV clk cycles per tick, STABLE_CNT ticks to accept a new
// level, ACTIVE_LOW inverts the raw pins before synchronisation.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned STABLE_CNT = 8,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BTN_W-1:0] btn_raw,
    output logic [BTN_W-1:0] btn_level,
    output logic [BTN_W-1:0] btn_press,
    output logic [BTN_W-1:0] btn_release,
    output logic             tick
);

    localparam int unsigned PW = $clog2(TICK_DIV) + 1;

    logic [PW-1:0]    pcnt;
    logic             run;
    logic [BTN_W-1:0] p;

    // run keeps tick low while reset is held; otherwise TICK_DIV=1 would
    // strobe tick during reset because pcnt==0 already matches TICK_DIV-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            run  <= 1'b0;
        end else begin
            run <= 1'b1;
            if (pcnt == PW'(TICK_DIV - 1)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

    always_comb begin
        tick = run && (pcnt == PW'(TICK_DIV - 1));
        p    = btn_raw ^ {BTN_W{ACTIVE_LOW}};
    end

    for (genvar i = 0; i < BTN_W; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CNT(STABLE_CNT)
        ) u_ch (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .raw  (p[i]),
            .level(btn_level[i]),
            .press(btn_press[i]),
            .rls  (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce.
// Main instance: TICK_DIV=4, STABLE_CNT=3, ACTIVE_LOW=0.
// Second instance: TICK_DIV=1, STABLE_CNT=1, ACTIVE_LOW=1.
module tb_button_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'h0;
    logic [3:0] btn_level, btn_press, btn_release;
    logic       tick;

    logic [3:0] raw2 = 4'hF;
    logic [3:0] level2, press2, release2;
    logic       tick2;

    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    typedef struct {
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  level;
        int unsigned lo;
        int unsigned hi;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    button_debounce #(.TICK_DIV(4), .STABLE_CNT(3), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .tick(tick)
    );

    button_debounce #(.TICK_DIV(1), .STABLE_CNT(1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .btn_raw(raw2), .btn_level(level2),
        .btn_press(press2), .btn_release(release2), .tick(tick2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every cycle with a pulse consumes one expected event.
    always @(negedge clk) begin
        if ((btn_press | btn_release) != 4'h0) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pulse: got press=%b release=%b expected none (cycle %0d)",
                         btn_press, btn_release, cyc);
            end else begin
                mon_e = q.pop_front();
                check({mon_e.name, "_press"}, 32'(btn_press), 32'(mon_e.press));
                check({mon_e.name, "_release"}, 32'(btn_release), 32'(mon_e.rel));
                check({mon_e.name, "_level"}, 32'(btn_level), 32'(mon_e.level));
                n_chk++;
                if (cyc < mon_e.lo || cyc > mon_e.hi) begin
                    n_fail++;
                    $display("FAIL %s_latency: got cycle %0d expected %0d..%0d",
                             mon_e.name, cyc, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    task automatic push_exp(input string name, input logic [3:0] pr, input logic [3:0] rl,
                            input logic [3:0] lv, input int unsigned base);
        exp_t e;
        e.press = pr; e.rel = rl; e.level = lv;
        e.lo = base + 11; e.hi = base + 14; e.name = name;
        q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d events pending expected 0", name, q.size());
            q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Change btn_raw just after a clock edge and expect one pulse event.
    task automatic step(input string name, input logic [3:0] nraw, input logic [3:0] pr,
                        input logic [3:0] rl, input logic [3:0] lv);
        @(posedge clk);
        #1;
        btn_raw = nraw;
        push_exp(name, pr, rl, lv, cyc);
        wait_done(name);
    endtask

    initial begin
        int unsigned k;
        int unsigned n;

        // 1: buttons held through reset
        btn_raw = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_level", 32'(btn_level), 32'h0);
            check("rst_press", 32'(btn_press | btn_release), 32'h0);
            check("rst_tick", 32'(tick), 32'h0);
        end
        check("rst_tick_al", 32'(tick2), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp("held_after_rst", 4'hF, 4'h0, 4'hF, cyc);
        wait_done("held_after_rst");
        step("rel_all", 4'h0, 4'h0, 4'hF, 4'h0);

        // 2: clean press on left
        step("press0", 4'b0001, 4'b0001, 4'b0000, 4'b0001);

        // 3: bounce on up, then settle high
        @(posedge clk);
        #1;
        for (int i = 0; i < 12; i++) begin
            btn_raw[2] = ~btn_raw[2];
            repeat (5) @(posedge clk);
            #1;
        end
        check("bounce_level", 32'(btn_level), 32'h1);
        step("bounce_press2", 4'b0101, 4'b0100, 4'b0000, 4'b0101);

        // 4: releases
        step("release0", 4'b0100, 4'b0000, 4'b0001, 4'b0100);
        step("release2", 4'b0000, 4'b0000, 4'b0100, 4'b0000);

        // 5: simultaneous press / release
        step("simul_press", 4'b0101, 4'b0101, 4'b0000, 4'b0101);
        step("simul_release", 4'b0000, 4'b0000, 4'b0101, 4'b0000);

        // 5b: reset while channel 0 has counted two ticks
        @(posedge clk);
        #1;
        btn_raw = 4'b0001;
        repeat (2) @(posedge clk);
        k = 0;
        for (int i = 0; i < 40 && k < 2; i++) begin
            @(negedge clk);
            if (tick) begin
                @(posedge clk);
                k++;
            end
        end
        check("mid_ticks_seen", 32'(k), 32'd2);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_level", 32'(btn_level), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp("mid_rst_press", 4'b0001, 4'b0000, 4'b0001, cyc);
        wait_done("mid_rst_press");
        step("mid_rst_release", 4'b0000, 4'b0000, 4'b0001, 4'b0000);

        // 6: active-low instance, single-tick acceptance
        @(posedge clk);
        #1;
        raw2[3] = 1'b0;
        n = cyc;
        for (int d = 0; d < 5; d++) begin
            @(negedge clk);
            check("al_level", 32'(level2), (cyc - n >= 3) ? 32'h8 : 32'h0);
            check("al_press", 32'(press2), (cyc - n == 3) ? 32'h8 : 32'h0);
            check("al_release", 32'(release2), 32'h0);
            check("al_tick", 32'(tick2), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
